load_wb_unit: RTL and testbench

// - Writer side of the byte-enabled register file: issues loads on the SRAM-like data bus, tracks outstanding loads,

---
 rtl/load_wb_unit_pkg.sv | 29 ++
 rtl/load_wb_unit_fifo.sv | 70 +++++++
 rtl/load_wb_unit.sv | 152 +++++++++++++++
 tb/tb_load_wb_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_wb_unit_pkg.sv
// load_wb_unit_pkg: types and constants shared by the load write-back unit.
//   ld_op_t    : load operation codes as presented by EX on ld_op.
//   ld_info_t  : per-load bookkeeping held between address acceptance and
//                data return ({op, byte offset, destination register}).
//   SIZE_*     : data_size encodings for the SRAM-like data bus.
package load_wb_unit_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LBU = 3'd1,
        LD_LH  = 3'd2,
        LD_LHU = 3'd3,
        LD_LW  = 3'd4,
        LD_LWL = 3'd5,
        LD_LWR = 3'd6,
        LD_RSV = 3'd7
    } ld_op_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        ld_op_t      op;
        logic [1:0]  off;
        logic [4:0]  dest;
    } ld_info_t;

endpackage

// File: rtl/load_wb_unit_fifo.sv
// ld_info_fifo: DEPTH-entry FIFO of ld_info_t records for loads whose address
// phase has completed but whose data has not yet returned.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (empties FIFO)
//   push, push_data write one entry (ignored when full without a pop)
//   pop, pop_data   pop_data is the current head; pop removes it (ignored when empty)
//   count           number of valid entries
//   full, empty     occupancy flags
module ld_info_fifo
    import load_wb_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  ld_info_t                     push_data,
    input  logic                         pop,
    output ld_info_t                     pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ld_info_t            mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_wb_unit.sv
// load_wb_unit: writer side of the byte-enabled register file. Issues loads on
// the SRAM-like data bus, tracks up to OUTSTANDING address-accepted loads,
// aligns returned words and drives the regfile write port for one cycle.
// Configuration: define LOAD_WB_UNALIGNED_EN to build LWL/LWR merge support;
// otherwise ops 5/6 behave as LW.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   ld_valid/ld_ready               load handshake from EX
//   ld_op, ld_addr, ld_dest         load operation, byte address, dest register
//   data_req/data_wr/data_size/data_addr   SRAM-like request (read only)
//   data_addr_ok, data_data_ok, data_rdata bus responses, data in request order
//   rf_we, rf_waddr, rf_wdata       regfile byte-enabled write port
//   busy                            request pending or load in flight
module load_wb_unit
    import load_wb_unit_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [2:0]   ld_op,
    input  logic [31:0]  ld_addr,
    input  logic [4:0]   ld_dest,
    output logic         data_req,
    output logic         data_wr,
    output logic [1:0]   data_size,
    output logic [31:0]  data_addr,
    input  logic         data_addr_ok,
    input  logic         data_data_ok,
    input  logic [31:0]  data_rdata,
    output logic [3:0]   rf_we,
    output logic [4:0]   rf_waddr,
    output logic [31:0]  rf_wdata,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    ld_info_t            pend_info;
    ld_info_t            head;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    logic                accept;
    logic                push;
    logic                pop;
    ld_op_t              op_in;
    logic [1:0]          req_size;
    logic [31:0]         req_addr;
    logic [7:0]          al_byte;
    logic [15:0]         al_half;
    logic [3:0]          al_we;
    logic [31:0]         al_wdata;

    // data_req doubles as the "request pending" flag: it is set on accept and
    // cleared once the bus takes the address.
    assign ld_ready = ~data_req & ~full;
    assign accept   = ld_valid & ld_ready;
    assign push     = data_req & data_addr_ok;
    assign pop      = data_data_ok & ~empty;
    assign data_wr  = 1'b0;
    assign busy     = data_req | (count != '0) | (rf_we != '0);
    assign op_in    = ld_op_t'(ld_op);

    ld_info_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_info_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pend_info),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        req_size = SIZE_WORD;
        req_addr = ld_addr;
        case (op_in)
            LD_LB, LD_LBU: req_size = SIZE_BYTE;
            LD_LH, LD_LHU: req_size = SIZE_HALF;
`ifdef LOAD_WB_UNALIGNED_EN
            LD_LWL, LD_LWR: req_addr = {ld_addr[31:2], 2'b00};
`endif
            default: ;
        endcase
    end

    // Data is taken from the bus word by the offset recorded at issue time.
    assign al_byte = data_rdata[{head.off, 3'b000} +: 8];
    assign al_half = data_rdata[{head.off[1], 4'b0000} +: 16];

    always_comb begin
        al_we    = 4'b1111;
        al_wdata = data_rdata;
        case (head.op)
            LD_LB:  al_wdata = {{24{al_byte[7]}}, al_byte};
            LD_LBU: al_wdata = {24'd0, al_byte};
            LD_LH:  al_wdata = {{16{al_half[15]}}, al_half};
            LD_LHU: al_wdata = {16'd0, al_half};
`ifdef LOAD_WB_UNALIGNED_EN
            // 3-a == ~a for a 2-bit offset.
            LD_LWL: begin
                al_wdata = data_rdata << {~head.off, 3'b000};
                al_we    = 4'b1111 << ~head.off;
            end
            LD_LWR: begin
                al_wdata = data_rdata >> {head.off, 3'b000};
                al_we    = 4'b1111 >> head.off;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_req  <= 1'b0;
            data_size <= '0;
            data_addr <= '0;
            pend_info <= '0;
            rf_we     <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            if (accept) begin
                data_req       <= 1'b1;
                data_size      <= req_size;
                data_addr      <= req_addr;
                pend_info.op   <= op_in;
                pend_info.off  <= ld_addr[1:0];
                pend_info.dest <= ld_dest;
            end else if (push) begin
                data_req <= 1'b0;
            end

            if (pop) begin
                rf_we    <= (head.dest == '0) ? '0 : al_we;
                rf_waddr <= head.dest;
                rf_wdata <= al_wdata;
            end else begin
                rf_we <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_wb_unit.sv
// Self-checking bench for load_wb_unit: a queue-based behavioural model is
// compared on every falling edge, and directed loads pin literal results.
module tb_load_wb_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_op = '0;
    logic [31:0] ld_addr = '0;
    logic [4:0]  ld_dest = '0;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    always #5 clk = ~clk;

    load_wb_unit #(
        .OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_op        (ld_op),
        .ld_addr      (ld_addr),
        .ld_dest      (ld_dest),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit go = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          op;
        logic [31:0] addr;
        int          dest;
    } ld_t;

    ld_t         m_q[$];
    bit          m_pend = 1'b0;
    ld_t         m_pl;
    logic [3:0]  m_we = '0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    function automatic int exp_size(input int op);
        if (op == 0 || op == 1) return 0;
        if (op == 2 || op == 3) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] exp_addr(input int op, input logic [31:0] a);
`ifdef LOAD_WB_UNALIGNED_EN
        if (op == 5 || op == 6) return a & 32'hFFFF_FFFC;
`endif
        return a + 32'd0 * op;
    endfunction

    function automatic void model_write(input int op, input int a, input logic [31:0] r,
                                        output logic [3:0] we, output logic [31:0] wd);
        logic [31:0] bytev;
        logic [31:0] halfv;
        bytev = (r >> (8 * a)) & 32'hFF;
        halfv = (r >> (16 * (a / 2))) & 32'hFFFF;
        we = 4'b1111;
        case (op)
            0: wd = bytev[7] ? (bytev | 32'hFFFF_FF00) : bytev;
            1: wd = bytev;
            2: wd = halfv[15] ? (halfv | 32'hFFFF_0000) : halfv;
            3: wd = halfv;
`ifdef LOAD_WB_UNALIGNED_EN
            5: begin
                wd = r << (8 * (3 - a));
                for (int j = 0; j < 4; j++) we[j] = (j >= 3 - a);
            end
            6: begin
                wd = r >> (8 * a);
                for (int j = 0; j < 4; j++) we[j] = (j <= 3 - a);
            end
`endif
            default: wd = r;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        bit          rdy;
        ld_t         e;
        logic [3:0]  we;
        logic [31:0] wd;
        if (reset) begin
            m_q.delete();
            m_pend  = 1'b0;
            m_we    = '0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            rdy  = !m_pend && (m_q.size() < 2);
            m_we = '0;
            if (data_data_ok && m_q.size() > 0) begin
                e = m_q.pop_front();
                model_write(e.op, int'(e.addr[1:0]), data_rdata, we, wd);
                m_we    = (e.dest == 0) ? 4'b0000 : we;
                m_waddr = 5'(e.dest);
                m_wdata = wd;
            end
            if (m_pend && data_addr_ok) begin
                m_q.push_back(m_pl);
                m_pend = 1'b0;
            end else if (ld_valid && rdy) begin
                m_pend     = 1'b1;
                m_pl.op    = int'(ld_op);
                m_pl.addr  = ld_addr;
                m_pl.dest  = int'(ld_dest);
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("ld_ready", 32'(ld_ready), 32'(!m_pend && (m_q.size() < 2)));
            chk("data_req", 32'(data_req), 32'(m_pend));
            chk("data_wr", 32'(data_wr), 32'd0);
            if (m_pend) begin
                chk("data_addr", data_addr, exp_addr(m_pl.op, m_pl.addr));
                chk("data_size", 32'(data_size), 32'(exp_size(m_pl.op)));
            end
            chk("rf_we", 32'(rf_we), 32'(m_we));
            if (m_we != '0) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                chk("rf_wdata", rf_wdata, m_wdata);
            end
            chk("busy", 32'(busy), 32'(m_pend || (m_q.size() != 0) || (m_we != '0)));
        end
    end

    // ---------------- stimulus helpers (start/end at posedge+1) ----------------
    task automatic issue(input int op, input logic [31:0] addr, input int dest);
        int t = 0;
        while (!ld_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ld_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ld_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        ld_valid = 1'b1;
        ld_op    = 3'(op);
        ld_addr  = addr;
        ld_dest  = 5'(dest);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic addr_ok_pulse();
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
    endtask

    task automatic data_ok_pulse(input logic [31:0] r);
        data_data_ok = 1'b1;
        data_rdata   = r;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
    endtask

    task automatic one_load(input string name, input int op, input logic [31:0] addr,
                            input int dest, input logic [31:0] r, input logic [31:0] x_addr,
                            input logic [3:0] x_we, input logic [31:0] x_wdata);
        issue(op, addr, dest);
        @(negedge clk);
        chk({name, "_addr"}, data_addr, x_addr);
        @(posedge clk); #1;
        addr_ok_pulse();
        data_ok_pulse(r);
        @(negedge clk);
        chk({name, "_we"}, 32'(rf_we), 32'(x_we));
        chk({name, "_waddr"}, 32'(rf_waddr), 32'(dest));
        chk({name, "_wdata"}, rf_wdata, x_wdata);
        @(posedge clk); #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        go = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_data_size", 32'(data_size), 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        one_load("lw",  4, 32'h100, 5, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
        one_load("lb",  0, 32'h103, 6, 32'h80112233, 32'h103, 4'b1111, 32'hFFFFFF80);
        one_load("lbu", 1, 32'h103, 6, 32'h80112233, 32'h103, 4'b1111, 32'h00000080);
        one_load("lh",  2, 32'h102, 7, 32'h80112233, 32'h102, 4'b1111, 32'hFFFF8011);
        one_load("lhu", 3, 32'h102, 7, 32'h80112233, 32'h102, 4'b1111, 32'h00008011);
`ifdef LOAD_WB_UNALIGNED_EN
        one_load("lwl", 5, 32'h201, 3, 32'h44332211, 32'h200, 4'b1100, 32'h22110000);
        one_load("lwr", 6, 32'h202, 3, 32'h44332211, 32'h200, 4'b0011, 32'h00004433);
`else
        one_load("lwl", 5, 32'h201, 3, 32'h44332211, 32'h201, 4'b1111, 32'h44332211);
        one_load("lwr", 6, 32'h202, 3, 32'h44332211, 32'h202, 4'b1111, 32'h44332211);
`endif
        one_load("rsv", 7, 32'h300, 4, 32'h0BADF00D, 32'h300, 4'b1111, 32'h0BADF00D);

        // Two outstanding, then push and pop in the same cycle.
        issue(4, 32'h400, 8);
        addr_ok_pulse();
        issue(1, 32'h405, 9);
        addr_ok_pulse();
        @(negedge clk);
        chk("two_out_ready", 32'(ld_ready), 32'd0);
        chk("two_out_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        data_ok_pulse(32'h11111111);
        @(negedge clk);
        chk("fifo0_waddr", 32'(rf_waddr), 32'd8);
        chk("fifo0_wdata", rf_wdata, 32'h11111111);
        @(posedge clk); #1;
        issue(2, 32'h40A, 10);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0000AB00;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("fifo1_waddr", 32'(rf_waddr), 32'd9);
        chk("fifo1_wdata", rf_wdata, 32'h000000AB);
        chk("pushpop_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        data_ok_pulse(32'h80010000);
        @(negedge clk);
        chk("fifo2_waddr", 32'(rf_waddr), 32'd10);
        chk("fifo2_wdata", rf_wdata, 32'hFFFF8001);
        @(posedge clk); #1;

        // Stray data_ok with nothing outstanding.
        data_ok_pulse(32'hFFFFFFFF);
        @(negedge clk);
        chk("stray_we", 32'(rf_we), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Destination register zero.
        issue(4, 32'h500, 0);
        addr_ok_pulse();
        data_ok_pulse(32'h12345678);
        @(negedge clk);
        chk("dest0_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        chk("dest0_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Reset with one outstanding and one request pending.
        issue(4, 32'h600, 11);
        addr_ok_pulse();
        issue(4, 32'h604, 12);
        #2 reset = 1'b1;
        #1;
        chk("midrst_req", 32'(data_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        data_ok_pulse(32'hCAFEBABE);
        @(negedge clk);
        chk("stale_we", 32'(rf_we), 32'd0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
